nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
//
// PURPOSE
//  Sequencer that adds two WIDTH-bit operands over several cycles using one
//  external 4-bit ripple-carry adder (x, y, cin -> s, cout).
//  Drives one 4-bit operand slice per cycle into the adder, LSB nibble first.
//  Registers the adder's carry-out as the next nibble's carry-in, and
//  assembles the sum.
//  Sits directly upstream and downstream of the 4-bit adder, which is
//  combinational and instantiated alongside it.
//  Valid/ready handshake on both operand input and result output.
//
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of 4 and >= 4
//              (NIB = WIDTH/4 nibbles)
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands a, b, c_in valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      initial carry-in
//  add_x      out  4      nibble of A to adder x
//  add_y      out  4      nibble of B to adder y
//  add_cin    out  1      carry to adder cin
//  add_s      in   4      adder sum, same cycle (combinational path)
//  add_cout   in   1      adder carry-out, same cycle
//  out_valid  out  1      result valid (DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  assembled sum, held stable while out_valid=1
//  c_out      out  1      final carry-out of MSB nibble
//  ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
//  busy       out  1      1 in RUN or DONE
//
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Reset -> IDLE.
//  - Reset values: in_ready=1, out_valid=0, busy=0; sum, c_out, ovf = 0;
//    internal operand, carry and index registers = 0.
//  - IDLE: in_ready=1. If in_valid, capture a, b, c_in; set carry=c_in and
//    idx=0; go to RUN.
//  - RUN, each cycle:
//      add_x = A_reg[4*idx +: 4], add_y = B_reg[4*idx +: 4], add_cin = carry.
//      At the clock edge: sum_reg[4*idx +: 4] <= add_s; carry <= add_cout;
//      idx <= idx + 1.
//      When idx == NIB-1: c_out <= add_cout, compute ovf, go to DONE.
//  - Latency: handshake accepted at edge t; RUN occupies NIB cycles;
//    out_valid=1 from the edge after the last nibble (t+NIB).
//  - DONE: out_valid=1; sum, c_out, ovf held. If out_ready, go to IDLE next
//    cycle. out_valid stays 1 for as long as out_ready=0.
//  - Outside RUN, add_x = add_y = 0 and add_cin = 0.
//  - in_ready=0 in RUN and DONE; in_valid there is ignored (no capture).
//  - No throughput overlap: one op per NIB+2 cycles minimum.
//  - Reset in any state aborts the op; no out_valid pulse; sum and flags
//    are cleared.
//  - WIDTH=4: exactly one RUN cycle.
//  - idx is ceil(log2(NIB)) bits wide (min 1) and never wraps past NIB-1.
//  - Widths:
//      sum is exactly WIDTH bits, modulo 2^WIDTH.
//      c_out is bit WIDTH of a+b+c_in.
//      ovf is a pure signed-overflow flag, independent of c_in usage.
//
// TESTING  (WIDTH=16, real 4-bit adder attached)
//  - a=0x1234, b=0x0FFF, c_in=0 -> sum=0x2233, c_out=0, ovf=0;
//    out_valid 4 cycles after accept.
//  - a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, ovf=0
//    (carry ripples through all nibbles).
//  - a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
//  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stable;
//    in_ready=0 throughout; a new in_valid is not captured until IDLE.
//  - Assert rst on the 2nd RUN cycle -> next cycle IDLE, in_ready=1,
//    sum=0, no out_valid.
//  - WIDTH=4 build: a=0x9, b=0x8, c_in=1 -> sum=0x2, c_out=1, ovf=1
//    after one RUN cycle.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder sequencer: feeds one nibble per cycle to an external
// combinational 4-bit adder, chains its carry and assembles the result.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;

  assign last = (idx == LAST);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_x     = 4'h0;
    add_y     = 4'h0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_x   = a_r[4*idx +: 4];
        add_y   = b_r[4*idx +: 4];
        add_cin = carry;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= add_s;
          carry           <= add_cout;
          if (last) begin
            c_out <= add_cout;
            // add_s[3] is the sum MSB on the final nibble
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[3] != a_r[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: WIDTH=16 and WIDTH=4 sequencers, each driving a
// behavioural 4-bit adder, compared against a plain-arithmetic model.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH=16 instance
  logic        in_valid, in_ready, c_in, add_cin, add_cout, out_valid, out_ready;
  logic        c_out, ovf, busy;
  logic [15:0] a, b, sum;
  logic [3:0]  add_x, add_y, add_s;

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  // WIDTH=4 instance
  logic       w_in_valid, w_in_ready, w_c_in, w_add_cin, w_add_cout, w_out_valid, w_out_ready;
  logic       w_c_out, w_ovf, w_busy;
  logic [3:0] w_a, w_b, w_sum, w_add_x, w_add_y, w_add_s;

  assign {w_add_cout, w_add_s} = {1'b0, w_add_x} + {1'b0, w_add_y} + {4'b0, w_add_cin};

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .c_in(w_c_in), .add_x(w_add_x), .add_y(w_add_y), .add_cin(w_add_cin),
    .add_s(w_add_s), .add_cout(w_add_cout), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf), .busy(w_busy)
  );

  // Carry entering nibble k = bit 4k of the sum of the low 4k bits plus cin.
  function automatic logic carry_into(input logic [15:0] x, input logic [15:0] y,
                                      input logic ci, input int k);
    logic [16:0] mask, t;
    if (k == 0) return ci;
    mask = (17'h1 << (4*k)) - 17'h1;
    t = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {16'h0, ci};
    return t[4*k];
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input int hold);
    logic [16:0] r;
    logic        eo;
    r  = {1'b0, ta} + {1'b0, tb} + {16'h0, tc};
    eo = (ta[15] == tb[15]) && (r[15] != ta[15]);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || add_x !== 4'h0 || add_cin !== 1'b0)
      begin errors++; $display("FAIL idle_state: in_ready=%b busy=%b add_x=%h add_cin=%b want 1 0 0 0",
                               in_ready, busy, add_x, add_cin); end
    a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (add_x !== ta[4*k +: 4] || add_y !== tb[4*k +: 4] ||
          add_cin !== carry_into(ta, tb, tc, k) || out_valid !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL run_nibble%0d: x=%h y=%h cin=%b ov=%b ir=%b want x=%h y=%h cin=%b ov=0 ir=0",
                                 k, add_x, add_y, add_cin, out_valid, in_ready,
                                 ta[4*k +: 4], tb[4*k +: 4], carry_into(ta, tb, tc, k)); end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || sum !== r[15:0] || c_out !== r[16] || ovf !== eo || busy !== 1'b1)
      begin errors++; $display("FAIL result %h+%h+%b: ov=%b sum=%h c=%b ovf=%b want ov=1 sum=%h c=%b ovf=%b",
                               ta, tb, tc, out_valid, sum, c_out, ovf, r[15:0], r[16], eo); end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== r[15:0] || c_out !== r[16] || ovf !== eo ||
          in_ready !== 1'b0 || add_x !== 4'h0)
        begin errors++; $display("FAIL done_hold%0d: ov=%b sum=%h ir=%b want ov=1 sum=%h ir=0",
                                 h, out_valid, sum, in_ready, r[15:0]); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL release: ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 ||
        c_out !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL reset: ir=%b ov=%b busy=%b sum=%h c=%b ovf=%b want 1 0 0 0000 0 0",
                               in_ready, out_valid, busy, sum, c_out, ovf); end
  endtask

  task automatic test_directed();
    do_op(16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1);
  endtask

  task automatic test_done_hold();
    do_op(16'hABCD, 16'h1111, 1'b1, 5);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 ||
        c_out !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL midrun_reset: ir=%b ov=%b busy=%b sum=%h want 1 0 0 0000",
                               in_ready, out_valid, busy, sum); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL midrun_quiet%0d: ov=%b busy=%b want 0 0", i, out_valid, busy); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if (n % 8 == 0) ra = 16'hFFFF;
      if (n % 8 == 1) rb = 16'h7FFF;
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_w4_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    logic [4:0] r;
    logic       eo;
    r  = {1'b0, ta} + {1'b0, tb} + {4'h0, tc};
    eo = (ta[3] == tb[3]) && (r[3] != ta[3]);
    @(negedge clk);
    w_a = ta; w_b = tb; w_c_in = tc; w_in_valid = 1'b1;
    @(posedge clk); #1 w_in_valid = 1'b0;
    checks++;
    if (w_add_x !== ta || w_add_y !== tb || w_add_cin !== tc || w_out_valid !== 1'b0)
      begin errors++; $display("FAIL w4_run: x=%h y=%h cin=%b ov=%b want %h %h %b 0",
                               w_add_x, w_add_y, w_add_cin, w_out_valid, ta, tb, tc); end
    @(posedge clk); #1;
    checks++;
    if (w_out_valid !== 1'b1 || w_sum !== r[3:0] || w_c_out !== r[4] || w_ovf !== eo)
      begin errors++; $display("FAIL w4_result %h+%h+%b: ov=%b sum=%h c=%b ovf=%b want 1 %h %b %b",
                               ta, tb, tc, w_out_valid, w_sum, w_c_out, w_ovf, r[3:0], r[4], eo); end
    w_out_ready = 1'b1;
    @(posedge clk); #1 w_out_ready = 1'b0;
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_busy !== 1'b0)
      begin errors++; $display("FAIL w4_release: ov=%b ir=%b busy=%b want 0 1 0",
                               w_out_valid, w_in_ready, w_busy); end
  endtask

  task automatic test_w4();
    test_w4_op(4'h9, 4'h8, 1'b1);
    for (int n = 0; n < 8; n++) test_w4_op(4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_done_hold();
    test_reset_midrun();
    test_random();
    test_w4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
